// File: rtl/sim_run_controller.sv
// Simulation run controller: holds the DUT in reset, then supervises completion and
// failure sources, a timeout and a drain window before latching a sticky verdict.
module sim_run_controller #(
  parameter int NUM_SRC      = 4,
  parameter int RESET_CYCLES = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] src_done,
  input  logic [NUM_SRC-1:0] src_fail,
  input  logic [63:0]        max_cycles,
  output logic               dut_reset,
  output logic               running,
  output logic               finished,
  output logic               failed,
  output logic [1:0]         reason,
  output logic [3:0]         fail_src,
  output logic [63:0]        cycle_count,
  output logic [NUM_SRC-1:0] done_mask
);

  localparam logic [31:0] HOLD_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [31:0]        hold_q;
  logic [31:0]        drain_q;
  logic [NUM_SRC-1:0] en_q;
  logic [63:0]        max_q;
  logic [NUM_SRC-1:0] done_mask_q;
  logic [NUM_SRC-1:0] done_mask_d;
  logic [63:0]        cycle_count_q;
  logic [63:0]        cycle_count_d;
  logic               dut_reset_q;
  logic               running_q;
  logic               finished_q;
  logic               failed_q;
  logic [1:0]         reason_q;
  logic [3:0]         fail_src_q;

  logic [NUM_SRC-1:0] fail_vec;
  logic [3:0]         fail_idx;
  logic               all_done;
  logic               timeout;

  // The timeout compares against the count that includes the current cycle, so a
  // limit of N allows exactly N run cycles and the counter stops at N.
  always_comb begin
    done_mask_d   = done_mask_q | (src_done & en_q);
    all_done      = ((done_mask_d & en_q) == en_q);
    fail_vec      = src_fail & en_q;
    cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 64'd1;
    timeout       = (max_q != 64'd0) && (cycle_count_d >= max_q);
    fail_idx      = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (fail_vec[i]) fail_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_q        <= 32'd0;
      drain_q       <= 32'd0;
      en_q          <= '0;
      max_q         <= 64'd0;
      done_mask_q   <= '0;
      cycle_count_q <= 64'd0;
      dut_reset_q   <= 1'b1;
      running_q     <= 1'b0;
      finished_q    <= 1'b0;
      failed_q      <= 1'b0;
      reason_q      <= 2'd0;
      fail_src_q    <= 4'd0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q     <= S_RUN;
            hold_q      <= 32'd0;
            en_q        <= src_en;
            max_q       <= max_cycles;
            dut_reset_q <= 1'b0;
            running_q   <= 1'b1;
          end else begin
            hold_q <= hold_q + 32'd1;
          end
        end
        S_RUN, S_DRAIN: begin
          cycle_count_q <= cycle_count_d;
          done_mask_q   <= done_mask_d;
          if (|fail_vec) begin
            state_q    <= S_DONE;
            running_q  <= 1'b0;
            failed_q   <= 1'b1;
            reason_q   <= 2'd1;
            fail_src_q <= fail_idx;
          end else if (timeout) begin
            state_q   <= S_DONE;
            running_q <= 1'b0;
            failed_q  <= 1'b1;
            reason_q  <= 2'd2;
          end else if (state_q == S_RUN) begin
            if (all_done) begin
              if (DRAIN_CYCLES == 0) begin
                state_q    <= S_DONE;
                running_q  <= 1'b0;
                finished_q <= 1'b1;
              end else begin
                state_q <= S_DRAIN;
                drain_q <= DRAIN_LOAD;
              end
            end
          end else if (drain_q == 32'd0) begin
            state_q    <= S_DONE;
            running_q  <= 1'b0;
            finished_q <= 1'b1;
          end else begin
            drain_q <= drain_q - 32'd1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign dut_reset   = dut_reset_q;
  assign running     = running_q;
  assign finished    = finished_q;
  assign failed      = failed_q;
  assign reason      = reason_q;
  assign fail_src    = fail_src_q;
  assign cycle_count = cycle_count_q;
  assign done_mask   = done_mask_q;

endmodule
